// File: rtl/systolic_array_top.sv
// 4x4 output-stationary systolic matrix-multiply engine with host-loaded
// operand/instruction memories and a 256-word result memory.
module systolic_array_top (
    input  logic               clk,
    input  logic               rst,
    input  logic        [5:0]  addrA,
    input  logic               enA,
    input  logic signed [15:0] dataA,
    input  logic        [5:0]  addrB,
    input  logic               enB,
    input  logic signed [15:0] dataB,
    input  logic        [1:0]  addrI,
    input  logic               enI,
    input  logic        [4:0]  dataI,
    input  logic        [7:0]  addrO,
    output logic signed [15:0] dataO,
    input  logic               ap_start,
    output logic               ap_done,
    output logic signed [15:0] r_00, r_01, r_02, r_03,
    output logic signed [15:0] r_10, r_11, r_12, r_13,
    output logic signed [15:0] r_20, r_21, r_22, r_23,
    output logic signed [15:0] r_30, r_31, r_32, r_33,
    output logic signed [15:0] data_o_0_A, data_o_1_A, data_o_2_A, data_o_3_A,
    output logic signed [15:0] data_o_0_B, data_o_1_B, data_o_2_B, data_o_3_B,
    output logic        [4:0]  instruction_wave
);

    typedef enum logic [2:0] {IDLE, FETCH, CLEAR, FEED, WRITE, DONE} state_t;

    state_t state, state_next;

    logic signed [15:0] mem_a [64];
    logic signed [15:0] mem_b [64];
    logic        [4:0]  mem_i [4];
    logic signed [15:0] mem_o [256];

    logic [1:0] pc;
    logic [4:0] t;
    logic [4:0] k_reg;
    logic [4:0] k_fetch;

    logic signed [15:0] feed_a [4];
    logic signed [15:0] feed_b [4];
    logic signed [15:0] feed_a_next [4];
    logic signed [15:0] feed_b_next [4];

    logic signed [15:0] acc   [4][4];
    logic signed [15:0] a_reg [4][4];
    logic signed [15:0] b_reg [4][4];
    logic signed [15:0] a_in  [4][4];
    logic signed [15:0] b_in  [4][4];
    logic signed [15:0] prod  [4][4];

    // Instruction words above 16 are clamped to the array's maximum depth
    assign k_fetch = (mem_i[pc] > 5'd16) ? 5'd16 : mem_i[pc];

    // Host write ports; these memories are deliberately not reset
    always_ff @(posedge clk) begin
        if (enA) mem_a[addrA] <= dataA;
        if (enB) mem_b[addrB] <= dataB;
        if (enI) mem_i[addrI] <= dataI;
    end

    // Result memory is filled row-major from the accumulators during WRITE
    always_ff @(posedge clk) begin
        if (state == WRITE) mem_o[{pc, t[3:0]}] <= acc[t[3:2]][t[1:0]];
    end

    // Registered read port for the host
    always_ff @(posedge clk) begin
        if (rst) dataO <= '0;
        else     dataO <= mem_o[addrO];
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic for the job sequencer
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (ap_start) state_next = FETCH;
            FETCH: state_next = (mem_i[pc] == 5'd0) ? DONE : CLEAR;
            CLEAR: state_next = FEED;
            FEED:  if (t == k_reg + 5'd6) state_next = WRITE;
            WRITE: if (t == 5'd15) state_next = (pc == 2'd3) ? DONE : FETCH;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Program counter, phase counter, current K and the status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            pc               <= '0;
            t                <= '0;
            k_reg            <= '0;
            ap_done          <= 1'b0;
            instruction_wave <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ap_start) begin
                        ap_done <= 1'b0;
                        pc      <= '0;
                    end
                end
                FETCH: begin
                    if (mem_i[pc] != 5'd0) begin
                        k_reg            <= k_fetch;
                        instruction_wave <= k_fetch;
                    end
                end
                CLEAR: t <= '0;
                FEED:  t <= (t == k_reg + 5'd6) ? 5'd0 : t + 5'd1;
                WRITE: begin
                    if (t == 5'd15) begin
                        t  <= '0;
                        pc <= pc + 2'd1;
                    end else begin
                        t <= t + 5'd1;
                    end
                end
                DONE: begin
                    ap_done          <= 1'b1;
                    instruction_wave <= '0;
                end
                default: ;
            endcase
        end
    end

    // Skewed feeder values: row/column n lags by n cycles, zero outside 0..K-1
    always_comb begin
        for (int n = 0; n < 4; n++) begin
            feed_a_next[n] = '0;
            feed_b_next[n] = '0;
            if (t >= 5'(n) && (t - 5'(n)) < k_reg) begin
                feed_a_next[n] = mem_a[{2'(n), 4'(t - 5'(n))}];
                feed_b_next[n] = mem_b[{4'(t - 5'(n)), 2'(n)}];
            end
        end
    end

    // Feeder registers only carry data during FEED
    always_ff @(posedge clk) begin
        for (int n = 0; n < 4; n++) begin
            if (rst || state != FEED) begin
                feed_a[n] <= '0;
                feed_b[n] <= '0;
            end else begin
                feed_a[n] <= feed_a_next[n];
                feed_b[n] <= feed_b_next[n];
            end
        end
    end

    // PE interconnect: A flows right, B flows down; products wrap to 16 bits
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            a_in[i][0] = feed_a[i];
            b_in[0][i] = feed_b[i];
            for (int j = 1; j < 4; j++) begin
                a_in[i][j] = a_reg[i][j-1];
                b_in[j][i] = b_reg[j-1][i];
            end
        end
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                prod[i][j] = a_in[i][j] * b_in[i][j];
            end
        end
    end

    // PE accumulators and pass-through registers
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (rst || state == CLEAR) begin
                    acc[i][j]   <= '0;
                    a_reg[i][j] <= '0;
                    b_reg[i][j] <= '0;
                end else if (state == FEED || state == WRITE) begin
                    acc[i][j]   <= acc[i][j] + prod[i][j];
                    a_reg[i][j] <= a_in[i][j];
                    b_reg[i][j] <= b_in[i][j];
                end
            end
        end
    end

    assign r_00 = acc[0][0];  assign r_01 = acc[0][1];
    assign r_02 = acc[0][2];  assign r_03 = acc[0][3];
    assign r_10 = acc[1][0];  assign r_11 = acc[1][1];
    assign r_12 = acc[1][2];  assign r_13 = acc[1][3];
    assign r_20 = acc[2][0];  assign r_21 = acc[2][1];
    assign r_22 = acc[2][2];  assign r_23 = acc[2][3];
    assign r_30 = acc[3][0];  assign r_31 = acc[3][1];
    assign r_32 = acc[3][2];  assign r_33 = acc[3][3];

    assign data_o_0_A = feed_a[0];  assign data_o_1_A = feed_a[1];
    assign data_o_2_A = feed_a[2];  assign data_o_3_A = feed_a[3];
    assign data_o_0_B = feed_b[0];  assign data_o_1_B = feed_b[1];
    assign data_o_2_B = feed_b[2];  assign data_o_3_B = feed_b[3];

endmodule

// File: tb/tb_systolic_array_top.sv
// Directed self-checking bench for systolic_array_top: table of constant-operand
// programs plus hand-written feeder, reset and busy-start sequences.
module tb_systolic_array_top;

    logic               clk;
    logic               rst;
    logic        [5:0]  addrA, addrB;
    logic               enA, enB, enI;
    logic signed [15:0] dataA, dataB;
    logic        [1:0]  addrI;
    logic        [4:0]  dataI;
    logic        [7:0]  addrO;
    logic signed [15:0] dataO;
    logic               ap_start;
    logic               ap_done;
    logic signed [15:0] r [16];
    logic signed [15:0] fa [4];
    logic signed [15:0] fb [4];
    logic        [4:0]  instruction_wave;

    int total_checks;
    int passed_checks;

    typedef struct {
        logic signed [15:0] a_val;
        logic signed [15:0] b_val;
        logic        [4:0]  prog [4];
        logic signed [15:0] exp_slot [4];
        logic signed [15:0] exp_r33;
        int                 exp_cycles;
    } vec_t;

    vec_t vecs [7];

    systolic_array_top dut (
        .clk(clk), .rst(rst),
        .addrA(addrA), .enA(enA), .dataA(dataA),
        .addrB(addrB), .enB(enB), .dataB(dataB),
        .addrI(addrI), .enI(enI), .dataI(dataI),
        .addrO(addrO), .dataO(dataO),
        .ap_start(ap_start), .ap_done(ap_done),
        .r_00(r[0]),  .r_01(r[1]),  .r_02(r[2]),  .r_03(r[3]),
        .r_10(r[4]),  .r_11(r[5]),  .r_12(r[6]),  .r_13(r[7]),
        .r_20(r[8]),  .r_21(r[9]),  .r_22(r[10]), .r_23(r[11]),
        .r_30(r[12]), .r_31(r[13]), .r_32(r[14]), .r_33(r[15]),
        .data_o_0_A(fa[0]), .data_o_1_A(fa[1]), .data_o_2_A(fa[2]), .data_o_3_A(fa[3]),
        .data_o_0_B(fb[0]), .data_o_1_B(fb[1]), .data_o_2_B(fb[2]), .data_o_3_B(fb[3]),
        .instruction_wave(instruction_wave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input int actual, input int expected);
        total_checks++;
        if (actual == expected) passed_checks++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_a(input int addr, input int val);
        addrA = 6'(addr); dataA = 16'(val); enA = 1'b1;
        step();
        enA = 1'b0;
    endtask

    task automatic write_b(input int addr, input int val);
        addrB = 6'(addr); dataB = 16'(val); enB = 1'b1;
        step();
        enB = 1'b0;
    endtask

    task automatic write_prog(input logic [4:0] p0, input logic [4:0] p1,
                              input logic [4:0] p2, input logic [4:0] p3);
        logic [4:0] p [4];
        p[0] = p0; p[1] = p1; p[2] = p2; p[3] = p3;
        for (int n = 0; n < 4; n++) begin
            addrI = 2'(n); dataI = p[n]; enI = 1'b1;
            step();
        end
        enI = 1'b0;
    endtask

    task automatic read_o(input int addr, output int val);
        addrO = 8'(addr);
        step();
        val = int'(dataO);
    endtask

    // A[i][k] = i+1 and B[k][j] = j+1
    task automatic load_ramp();
        for (int n = 0; n < 64; n++) begin
            write_a(n, n / 16 + 1);
            write_b(n, n % 4 + 1);
        end
    endtask

    // Start pulse, then wait (bounded) for ap_done; optionally re-pulse while busy
    task automatic apply_stimulus(input bit pulse_busy, output int cycles);
        ap_start = 1'b1;
        step();
        ap_start = 1'b0;
        cycles = 0;
        while (!ap_done && cycles < 2000) begin
            ap_start = pulse_busy && (cycles == 5 || cycles == 20);
            step();
            cycles++;
        end
        ap_start = 1'b0;
    endtask

    task automatic set_vec(input int idx, input int a, input int b,
                           input int p0, input int p1, input int p2, input int p3,
                           input int e0, input int e1, input int e2, input int e3,
                           input int r33, input int cyc);
        vecs[idx].a_val = 16'(a);
        vecs[idx].b_val = 16'(b);
        vecs[idx].prog[0] = 5'(p0); vecs[idx].prog[1] = 5'(p1);
        vecs[idx].prog[2] = 5'(p2); vecs[idx].prog[3] = 5'(p3);
        vecs[idx].exp_slot[0] = 16'(e0); vecs[idx].exp_slot[1] = 16'(e1);
        vecs[idx].exp_slot[2] = 16'(e2); vecs[idx].exp_slot[3] = 16'(e3);
        vecs[idx].exp_r33 = 16'(r33);
        vecs[idx].exp_cycles = cyc;
    endtask

    initial begin
        int cycles;
        int val;
        total_checks = 0;
        passed_checks = 0;
        rst = 1'b1; ap_start = 1'b0;
        enA = 1'b0; enB = 1'b0; enI = 1'b0;
        addrA = '0; addrB = '0; addrI = '0; addrO = '0;
        dataA = '0; dataB = '0; dataI = '0;

        // Output slots accumulate across vectors, so leftovers appear in later rows
        set_vec(0,     1, 1,  4, 8, 16, 0,     4,   8,  16,   0,    16, 105);
        set_vec(1,    -3, 7, 16, 0,  0, 0,  -336,   8,  16,   0,  -336,  43);
        set_vec(2, 16384, 4,  1, 0,  0, 0,     0,   8,  16,   0,     0,  28);
        set_vec(3,     1, 1, 20, 0,  0, 0,    16,   8,  16,   0,    16,  43);
        set_vec(4,     2, 3,  3, 5,  0, 7,    18,  30,  16,   0,    30,  60);
        set_vec(5,     1, -1, 16, 16, 16, 16, -16, -16, -16, -16,   -16, 165);
        set_vec(6,     5, 5,  0, 3,  3, 3,   -16, -16, -16, -16,   -16,   2);

        repeat (2) @(posedge clk);
        #1;
        check_output("reset ap_done", int'(ap_done), 0);
        check_output("reset instruction_wave", int'(instruction_wave), 0);
        check_output("reset dataO", int'(dataO), 0);
        check_output("reset r_00", int'(r[0]), 0);
        check_output("reset data_o_0_A", int'(fa[0]), 0);
        rst = 1'b0;
        step();

        // Feeder skew observation followed by a reset in the middle of FEED
        load_ramp();
        write_prog(5'd2, 5'd0, 5'd0, 5'd0);
        ap_start = 1'b1;
        step();
        ap_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_output("feed t0 data_o_1_A", int'(fa[1]), 0);
        check_output("feed t0 data_o_0_A", int'(fa[0]), 1);
        check_output("feed t0 data_o_0_B", int'(fb[0]), 1);
        check_output("feed instruction_wave", int'(instruction_wave), 2);
        step();
        check_output("feed t1 data_o_1_A", int'(fa[1]), 2);
        check_output("feed t1 data_o_1_B", int'(fb[1]), 2);
        check_output("feed t1 r_00", int'(r[0]), 1);
        step();
        rst = 1'b1;
        step();
        for (int n = 0; n < 16; n++)
            check_output($sformatf("midreset r%0d", n), int'(r[n]), 0);
        for (int n = 0; n < 4; n++) begin
            check_output($sformatf("midreset feedA%0d", n), int'(fa[n]), 0);
            check_output($sformatf("midreset feedB%0d", n), int'(fb[n]), 0);
        end
        check_output("midreset ap_done", int'(ap_done), 0);
        check_output("midreset instruction_wave", int'(instruction_wave), 0);
        check_output("midreset dataO", int'(dataO), 0);
        rst = 1'b0;
        step();

        // Full K=2 run after the reset, then again with spurious starts while busy
        for (int pass = 0; pass < 2; pass++) begin
            apply_stimulus(pass == 1, cycles);
            check_output($sformatf("ramp%0d latency", pass), cycles, 29);
            check_output($sformatf("ramp%0d ap_done", pass), int'(ap_done), 1);
            check_output($sformatf("ramp%0d instruction_wave", pass), int'(instruction_wave), 0);
            check_output($sformatf("ramp%0d r_33", pass), int'(r[15]), 32);
            check_output($sformatf("ramp%0d r_12", pass), int'(r[6]), 12);
            for (int w = 0; w < 16; w++) begin
                read_o(w, val);
                check_output($sformatf("ramp%0d word%0d", pass, w), val,
                             2 * (w / 4 + 1) * (w % 4 + 1));
            end
        end

        // Table of constant-operand programs
        for (int v = 0; v < 7; v++) begin
            for (int n = 0; n < 64; n++) begin
                write_a(n, int'(vecs[v].a_val));
                write_b(n, int'(vecs[v].b_val));
            end
            write_prog(vecs[v].prog[0], vecs[v].prog[1], vecs[v].prog[2], vecs[v].prog[3]);
            apply_stimulus(1'b0, cycles);
            check_output($sformatf("vec%0d latency", v), cycles, vecs[v].exp_cycles);
            check_output($sformatf("vec%0d ap_done", v), int'(ap_done), 1);
            check_output($sformatf("vec%0d r_33", v), int'(r[15]), int'(vecs[v].exp_r33));
            for (int w = 0; w < 64; w++) begin
                read_o(w, val);
                check_output($sformatf("vec%0d word%0d", v, w), val,
                             int'(vecs[v].exp_slot[w / 16]));
            end
        end

        // Words beyond the four job slots are never written
        for (int w = 64; w < 256; w++) begin
            read_o(w, val);
            check_output($sformatf("unused word%0d", w), val, 0);
        end

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
